hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller driving the stall/flush side of the IF/ID pipeline register and the PC. It detects load-use hazards between ID and EX, converts a taken branch resolved in ID into an IF flush, and freezes the whole pipeline for multi-cycle data-memory stalls. A bounded wait FSM stops a hung memory from stalling forever.

---
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : IF/ID stall/flush, PC-write and pipeline-freeze controller with
//            load-use detection, branch flush and a bounded memory-wait FSM.
//            Optional performance counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  ID_rs1_i,
    input  logic [4:0]  ID_rs2_i,
    input  logic        EX_memread_i,
    input  logic [4:0]  EX_rd_i,
    input  logic        branch_taken_i,
    input  logic        mem_stall_i,
    output logic        PC_write_o,
    output logic        IF_stall_o,
    output logic        IF_flush_o,
    output logic        ID_bubble_o,
    output logic        pipe_hold_o,
    output logic        err_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_ERROR    = 2'd3
    } state_t;

    localparam logic [7:0] c_timeout = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;

    logic w_load_use;
    logic w_pc_write;
    logic w_if_stall;
    logic w_if_flush;
    logic w_id_bubble;
    logic w_pipe_hold;

    // A load whose destination is x0 never creates a real dependency.
    assign w_load_use = EX_memread_i && (EX_rd_i != 5'd0) &&
                        ((EX_rd_i == ID_rs1_i) || (EX_rd_i == ID_rs2_i));

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_pc_write     = 1'b0;
        w_if_stall     = 1'b1;
        w_if_flush     = 1'b0;
        w_id_bubble    = 1'b0;
        w_pipe_hold    = 1'b0;
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                w_wait_cnt_nxt = 8'd0;
                if (start_i) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_RUN, S_MEM_WAIT: begin
                if (mem_stall_i) begin
                    w_pipe_hold = 1'b1;
                    if (r_state == S_RUN) begin
                        w_state_nxt    = S_MEM_WAIT;
                        w_wait_cnt_nxt = 8'd1;
                    end else if (r_wait_cnt == c_timeout) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    // Memory released: normal RUN decisions apply this same cycle.
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = 8'd0;
                    if (w_load_use) begin
                        w_id_bubble = 1'b1;
                    end else begin
                        w_pc_write = 1'b1;
                        w_if_stall = 1'b0;
                        w_if_flush = branch_taken_i;
                    end
                end

                if (!start_i) begin
                    w_state_nxt    = S_IDLE;
                    w_wait_cnt_nxt = 8'd0;
                end
            end

            S_ERROR: begin
                w_pipe_hold = 1'b1;
            end

            default: begin
                w_state_nxt    = S_IDLE;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    assign PC_write_o  = w_pc_write;
    assign IF_stall_o  = w_if_stall;
    assign IF_flush_o  = w_if_flush;
    assign ID_bubble_o = w_id_bubble;
    assign pipe_hold_o = w_pipe_hold;
    assign err_o       = (r_state == S_ERROR);
    assign state_o     = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_count_stall;

    assign w_count_stall = !w_pc_write && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_count_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_if_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed plus randomized bench for hazard_ctrl (TIMEOUT=4) with a
//            cycle-level reference model built from the controller's rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [4:0]  rs1, rs2, rd;
    logic        memread, br, ms;
    logic        PC_write_o, IF_stall_o, IF_flush_o, ID_bubble_o, pipe_hold_o, err_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: "started", "errored" and the length of the current
    // run of consecutive memory-stall cycles.
    bit          m_started, m_err;
    int          m_run;
    logic [31:0] m_stall_cnt, m_flush_cnt;
    logic        x_pc, x_fl;

    hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .ID_rs1_i      (rs1),
        .ID_rs2_i      (rs2),
        .EX_memread_i  (memread),
        .EX_rd_i       (rd),
        .branch_taken_i(br),
        .mem_stall_i   (ms),
        .PC_write_o    (PC_write_o),
        .IF_stall_o    (IF_stall_o),
        .IF_flush_o    (IF_flush_o),
        .ID_bubble_o   (ID_bubble_o),
        .pipe_hold_o   (pipe_hold_o),
        .err_o         (err_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_err       = 1'b0;
        m_run       = 0;
        m_stall_cnt = 32'd0;
        m_flush_cnt = 32'd0;
    endtask

    task automatic check_all(input string tag);
        logic       lu, e_st, e_bb, e_hd;
        logic [1:0] e_state;
        lu   = memread && (rd != 5'd0) && (rd == rs1 || rd == rs2);
        x_pc = 1'b0; e_st = 1'b1; x_fl = 1'b0; e_bb = 1'b0; e_hd = 1'b0;
        if (m_err || (m_started && ms)) begin
            e_hd = 1'b1;
        end else if (m_started) begin
            if (lu) begin
                e_bb = 1'b1;
            end else begin
                x_pc = 1'b1;
                e_st = 1'b0;
                x_fl = br;
            end
        end
        e_state = m_err ? 2'd3 : (!m_started ? 2'd0 : ((m_run > 0) ? 2'd2 : 2'd1));
        chk({tag, ".state"},  {30'd0, state_o},  {30'd0, e_state});
        chk({tag, ".pcw"},    {31'd0, PC_write_o},  {31'd0, x_pc});
        chk({tag, ".ifst"},   {31'd0, IF_stall_o},  {31'd0, e_st});
        chk({tag, ".flush"},  {31'd0, IF_flush_o},  {31'd0, x_fl});
        chk({tag, ".bubble"}, {31'd0, ID_bubble_o}, {31'd0, e_bb});
        chk({tag, ".hold"},   {31'd0, pipe_hold_o}, {31'd0, e_hd});
        chk({tag, ".err"},    {31'd0, err_o},       {31'd0, m_err});
        chk({tag, ".scnt"},   stall_cnt_o, m_stall_cnt);
        chk({tag, ".fcnt"},   flush_cnt_o, m_flush_cnt);
    endtask

    task automatic model_edge();
        if (PERF_EN) begin
            if ((m_started || m_err) && !x_pc && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (x_fl && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        if (!m_err) begin
            if (!m_started) begin
                if (start_i) m_started = 1'b1;
            end else if (!start_i) begin
                m_started = 1'b0;
                m_run     = 0;
            end else if (ms) begin
                m_run++;
                if (m_run > TIMEOUT) m_err = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    // One clock cycle: drive just after the edge, check mid-cycle, update model at the edge.
    task automatic step(input string tag, input logic st, input logic [4:0] a, input logic [4:0] b,
                        input logic mr, input logic [4:0] d, input logic bt, input logic m);
        start_i = st; rs1 = a; rs2 = b; memread = mr; rd = d; br = bt; ms = m;
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset(input string tag);
        rst_i = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        rst_i = 1'b1;
        #1;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        memread = 1'b0; br = 1'b0; ms = 1'b0;
        model_reset();
        x_pc = 1'b0; x_fl = 1'b0;
        #12;
        check_all("reset");
        rst_i = 1'b1;
        @(posedge clk); #1;

        step("idle",   1, 0, 0, 0, 0, 0, 0);
        step("run",    1, 1, 2, 0, 0, 0, 0);
        step("lu",     1, 1, 5, 1, 5, 0, 0);
        step("lu_aft", 1, 1, 5, 0, 5, 0, 0);
        step("lu_x0",  1, 0, 0, 1, 0, 0, 0);
        step("br",     1, 3, 4, 0, 0, 1, 0);
        step("br_aft", 1, 3, 4, 0, 0, 0, 0);
        step("br_lu",  1, 7, 2, 1, 7, 1, 0);
        for (int i = 0; i < 3; i++) step("ms_lu", 1, 6, 6, 1, 6, 0, 1);
        step("ms_end", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step("ms_max", 1, 0, 0, 0, 0, 0, 1);
        step("ms_maxend", 1, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TIMEOUT + 1; i++) step("ms_to", 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step("err_stk", 0, 1, 1, 1, 1, 1, 0);
        async_reset("err_rst");
        step("rst_idle", 1, 0, 0, 0, 0, 0, 0);
        step("rst_run",  1, 0, 0, 0, 0, 0, 1);
        step("ms_stop",  0, 0, 0, 0, 0, 0, 1);
        step("back_idle", 1, 0, 0, 0, 0, 0, 0);
        step("run2",      1, 0, 0, 0, 0, 0, 1);
        async_reset("wait_rst");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            step("rnd",
                 $urandom_range(0, 49) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
